// File: rtl/serial_sub_pkg.sv
// ============================================================================
//  Package     : serial_sub_pkg
//  Description : Shared types and constants for the bit-serial subtractor.
//                Holds the FSM state encoding and the default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

  // Default operand/result width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_sub_pkg

`default_nettype wire

// File: rtl/Subtractor1bit.sv
// ============================================================================
//  Module      : Subtractor1bit
//  Description : Combinational one-bit full subtractor.
//                D    = A ^ B ^ Bin
//                Bout = (~A & B) | (~(A ^ B) & Bin)
//  Ports       : A    - minuend bit
//                B    - subtrahend bit
//                Bin  - borrow in
//                D    - difference bit
//                Bout - borrow out
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module Subtractor1bit (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  logic a_xor_b;

  assign a_xor_b = A ^ B;
  assign D       = a_xor_b ^ Bin;
  assign Bout    = (~A & B) | (~a_xor_b & Bin);

endmodule : Subtractor1bit

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial subtractor computing D = A - B - Bin (mod 2^WIDTH)
//                one bit per clock, LSB first, using a single time-multiplexed
//                one-bit subtractor. Operands are captured on an accepted
//                start; the result and borrow-out are held until the next one.
//  Parameters  : WIDTH - operand/result width, 1..32
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                start - begin a subtraction (sampled in IDLE or DONE only)
//                A, B  - minuend, subtrahend
//                Bin   - borrow in
//                busy  - high while bits are being processed (WIDTH cycles)
//                done  - one-cycle pulse when D/Bout are valid
//                D     - difference
//                Bout  - borrow out (1 when A < B + Bin, unsigned)
//                V     - signed overflow (only with SERIAL_SUB_OVERFLOW_EN)
//  Macros      : SERIAL_SUB_OVERFLOW_EN - adds the signed-overflow output V
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  // Counter must be able to hold WIDTH itself so it never wraps mid-operation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic             last;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_next;
  logic             borrow;
  logic             bit_d;
  logic             bit_bout;

  assign last = (cnt == LAST_BIT);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // start here chains straight into the next operation.
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // --------------------------------------------------------------------------
  // Datapath: operands shift right so bit 0 is always the current bit; the
  // result shifts in from the top so after WIDTH steps bit 0 is the LSB.
  // --------------------------------------------------------------------------
  Subtractor1bit u_bit (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Bin  (borrow),
    .D    (bit_d),
    .Bout (bit_bout)
  );

  always_comb begin
    d_next            = D >> 1;
    d_next[WIDTH-1]   = bit_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      D      <= '0;
    end else if (load) begin
      a_sr   <= A;
      b_sr   <= B;
      borrow <= Bin;
      cnt    <= '0;
      D      <= '0;
    end else if (state_q == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      borrow <= bit_bout;
      cnt    <= cnt + CW'(1);
      D      <= d_next;
    end
  end

  // The borrow flop ends holding the borrow out of the MSB.
  assign Bout = borrow;

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Overflow = borrow into the MSB XOR borrow out of the MSB, captured on the
  // final bit while both are visible at the one-bit subtractor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      V <= 1'b0;
    end else if (load) begin
      V <= 1'b0;
    end else if ((state_q == RUN) && last) begin
      V <= borrow ^ bit_bout;
    end
  end
`endif

endmodule : serial_subtractor

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Directed self-checking bench for serial_subtractor (WIDTH=8
//                main instance plus a WIDTH=1 instance).
//  Macros      : SERIAL_SUB_OVERFLOW_EN - also checks the V output
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       Bin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] D;
  logic       Bout;
  logic       V;

  logic       start1 = 1'b0;
  logic [0:0] A1 = '0;
  logic [0:0] B1 = '0;
  logic       Bin1 = 1'b0;
  logic       busy1;
  logic       done1;
  logic [0:0] D1;
  logic       Bout1;
  logic       V1;

  int total_cnt  = 0;
  int passed_cnt = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .V     (V)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .A     (A1),
    .B     (B1),
    .Bin   (Bin1),
    .busy  (busy1),
    .done  (done1),
    .D     (D1),
    .Bout  (Bout1)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .V     (V1)
`endif
  );

`ifndef SERIAL_SUB_OVERFLOW_EN
  assign V  = 1'b0;
  assign V1 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      passed_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation on the WIDTH=8 instance and check its full result.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] exp_d, input logic exp_bout,
                        input logic exp_v);
    int n;
    A = a; B = b; Bin = bin; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, n, 8);
    check({tag, "_done"}, done, 1);
    check({tag, "_D"}, D, exp_d);
    check({tag, "_Bout"}, Bout, exp_bout);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({tag, "_V"}, V, exp_v);
`else
    if (exp_v === 1'bx) $display("unused");
`endif
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_D_hold"}, D, exp_d);
  endtask

  initial begin
    int n;
    int dones;
    int t1;
    int t2;
    logic [7:0] d1;
    logic [7:0] d2;

    // Reset state
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_D", D, 0);
    check("rst_Bout", Bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic vectors
    run_op("op_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("op_03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("op_00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("op_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("op_7F_FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("op_A5_5A_b", 8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1);

    // Start and operand changes during RUN are ignored
    A = 8'h05; B = 8'h03; Bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    A = 8'hFF; B = 8'h11; Bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    d1 = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dones++;
        d1 = D;
      end
      tick();
    end
    check("ignore_start_dones", dones, 1);
    check("ignore_start_D", d1, 8'h02);
    check("ignore_start_idle", busy, 0);

    // Asynchronous reset at RUN cycle 4
    A = 8'hFF; B = 8'h00; Bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_D", D, 0);
    check("abort_Bout", Bout, 0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      tick();
    end
    check("abort_no_done", dones, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("after_abort", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    // start held across done: back-to-back operations
    A = 8'h05; B = 8'h03; Bin = 1'b0; start = 1'b1;
    tick();
    A = 8'h03; B = 8'h05;
    dones = 0; t1 = 0; t2 = 0; d1 = '0; d2 = '0;
    n = 0;
    while (dones < 2 && n < 40) begin
      n++;
      if (done) begin
        dones++;
        if (dones == 1) begin t1 = n; d1 = D; end
        else begin t2 = n; d2 = D; start = 1'b0; end
      end
      if (dones < 2) tick();
    end
    start = 1'b0;
    check("b2b_two_dones", dones, 2);
    check("b2b_gap", t2 - t1, 9);
    check("b2b_D1", d1, 8'h02);
    check("b2b_D2", d2, 8'hFE);
    tick();
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_done", done, 0);

    // WIDTH=1 instance: 0 - 1 = 1 with borrow, one busy cycle
    A1 = 1'b0; B1 = 1'b1; Bin1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("w1_busy", busy1, 1);
    tick();
    check("w1_busy_end", busy1, 0);
    check("w1_done", done1, 1);
    check("w1_D", D1, 1);
    check("w1_Bout", Bout1, 1);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("w1_V", V1, 1);
`endif
    tick();
    check("w1_done_pulse", done1, 0);

    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule : tb_serial_subtractor

`default_nettype wire
